digit_serial_addsub: RTL

//  Multi-cycle N-bit adder/subtractor. Processes operands D bits per clock, LSB digit first, with a carry register between digits.

---
 rtl/digit_serial_addsub_pkg.sv | 17 +
 rtl/digit_serial_addsub_if.sv | 30 +++
 rtl/digit_serial_addsub_adder_slice.sv | 18 +
 rtl/digit_serial_addsub.sv | 118 +++++++++++
 4 files changed

// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e     : FSM state encoding (idle / run / done)
//   clog2_min1  : counter width helper, never returns less than 1 bit
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // A one-digit configuration still needs a 1-bit counter to exist.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Operand/result handshake bundle for digit_serial_addsub.
//   master : producer of operands and consumer of results (drives in_valid, x, y, sub, out_ready)
//   slave  : the arithmetic block (drives in_ready, out_valid, s, c_out, overflow, zero)
interface digit_serial_addsub_if #(
  parameter int unsigned N = 16
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, out_valid, s, c_out, overflow, zero
  );

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, out_valid, s, c_out, overflow, zero
  );

endinterface

// File: rtl/digit_serial_addsub_adder_slice.sv
// One D-bit ripple digit of the serial adder: {c_o, sum_o} = a_i + b_i + c_i.
//   a_i, b_i : operand digits
//   c_i      : carry in from the previous digit
//   sum_o    : digit sum
//   c_o      : carry out to the next digit
module digit_serial_addsub_adder_slice #(
  parameter int unsigned D = 4
) (
  input  logic [D-1:0] a_i,
  input  logic [D-1:0] b_i,
  input  logic         c_i,
  output logic [D-1:0] sum_o,
  output logic         c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + (D + 1)'(c_i);

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle N-bit adder/subtractor, D bits per clock, LSB digit first.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of digit_serial_addsub_if (operands in, result + flags out)
// One operation takes N/D run cycles plus one cycle to present the result; the block
// does not accept a new operation until the current result has been taken.
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned D = 4
) (
  input logic                 clk,
  input logic                 reset,
  digit_serial_addsub_if.slave bus
);

  localparam int unsigned NumDigits = N / D;
  localparam int unsigned CntW      = clog2_min1(NumDigits);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

  if ((N % D) != 0) begin : g_bad_digit
    $error("digit_serial_addsub: N must be a multiple of D");
  end

  state_e          state_q;
  logic [N-1:0]    xa_q, yb_q, res_q, s_q;
  logic [CntW-1:0] cnt_q;
  logic            carry_q, xs_q, ys_q;
  logic            c_out_q, ovf_q, zero_q, out_valid_q;

  logic [D-1:0]    dig;
  logic            dig_c;
  logic [N-1:0]    yb_in;
  logic [N-1:0]    res_next;
  logic            ovf_next;

  digit_serial_addsub_adder_slice #(
    .D (D)
  ) u_slice (
    .a_i   (xa_q[D-1:0]),
    .b_i   (yb_q[D-1:0]),
    .c_i   (carry_q),
    .sum_o (dig),
    .c_o   (dig_c)
  );

  always_comb begin
    // Subtraction is x + ~y + 1; the +1 rides in as the initial carry.
    yb_in    = bus.y ^ {N{bus.sub}};
    // New digit enters at the top so after N/D shifts the LSB digit sits at bit 0.
    res_next = (res_q >> D) | (N'(dig) << (N - D));
    ovf_next = (xs_q & ys_q & ~res_next[N-1]) | (~xs_q & ~ys_q & res_next[N-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      xa_q        <= '0;
      yb_q        <= '0;
      res_q       <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            xa_q    <= bus.x;
            yb_q    <= yb_in;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            res_q   <= '0;
            xs_q    <= bus.x[N-1];
            ys_q    <= yb_in[N-1];
            state_q <= StRun;
          end
        end
        StRun: begin
          xa_q    <= xa_q >> D;
          yb_q    <= yb_q >> D;
          res_q   <= res_next;
          carry_q <= dig_c;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            s_q         <= res_next;
            c_out_q     <= dig_c;
            ovf_q       <= ovf_next;
            zero_q      <= (res_next == '0);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Result flags stay in s_q/c_out_q/... after the handshake until the next load.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule
